// File: rtl/traceback_direction_reader.sv
// Needleman-Wunsch traceback walker: reads the direction RAM from (N,N)
// back to (0,0) and streams one path step per visited cell.
module traceback_direction_reader #(
  parameter int N = 128,
  parameter int BitAddr = $clog2(N+1),
  parameter int addr_lenght = $clog2((N+1)*(N+1)),
  parameter logic [2:0] DIAG = 3'b001,
  parameter logic [2:0] UP = 3'b010,
  parameter logic [2:0] LEFT = 3'b100
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic ram_en,
  output logic [addr_lenght-1:0] ram_addr,
  input  logic [2:0] ram_data,
  output logic step_valid,
  input  logic step_ready,
  output logic [2:0] step_dir,
  output logic [BitAddr-1:0] step_i,
  output logic [BitAddr-1:0] step_j,
  output logic busy,
  output logic done,
  output logic error
);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, EMIT, DONE, ERR
  } state_t;

  localparam logic [BitAddr-1:0] IMAX = BitAddr'(N);
  localparam logic [BitAddr-1:0] ONE = BitAddr'(1);
  localparam logic [addr_lenght-1:0] ROW = addr_lenght'(N+1);

  state_t state_q, state_d;
  logic [BitAddr-1:0] i_q, i_d;
  logic [BitAddr-1:0] j_q, j_d;
  logic [2:0] sym_q, sym_d;
  logic [addr_lenght-1:0] addr_d;
  logic i_nz, j_nz, legal;

  assign i_nz = (i_q != '0);
  assign j_nz = (j_q != '0);

  // A move may never step past row 0 or column 0.
  assign legal = (ram_data == DIAG && i_nz && j_nz)
              || (ram_data == UP && i_nz)
              || (ram_data == LEFT && j_nz);

  always_comb begin
    state_d = state_q;
    i_d = i_q;
    j_d = j_q;
    sym_d = sym_q;
    unique case (state_q)
      IDLE, ERR: begin
        if (start) begin
          i_d = IMAX;
          j_d = IMAX;
          state_d = REQ;
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        sym_d = ram_data;
        state_d = legal ? EMIT : ERR;
      end
      EMIT: begin
        if (step_ready) begin
          i_d = (sym_q != LEFT) ? i_q - ONE : i_q;
          j_d = (sym_q != UP) ? j_q - ONE : j_q;
          state_d = (i_d == '0 && j_d == '0) ? DONE : REQ;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    addr_d = ram_addr;
    if (state_d == REQ)
      addr_d = addr_lenght'(i_d) * ROW + addr_lenght'(j_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      i_q <= '0;
      j_q <= '0;
      sym_q <= '0;
      ram_en <= 1'b0;
      ram_addr <= '0;
      step_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      j_q <= j_d;
      sym_q <= sym_d;
      ram_en <= (state_d == REQ);
      ram_addr <= addr_d;
      step_valid <= (state_d == EMIT);
      busy <= (state_d != IDLE);
      done <= (state_d == DONE);
      error <= (state_d == ERR);
    end
  end

  assign step_dir = sym_q;
  assign step_i = i_q;
  assign step_j = j_q;

endmodule

// File: tb/tb_traceback_direction_reader.sv
// Directed bench for traceback_direction_reader on a 5x5 matrix
// with a behavioural one-cycle-latency direction RAM.
module tb_traceback_direction_reader;

  localparam int N = 4;
  localparam int BA = $clog2(N+1);
  localparam int AL = $clog2((N+1)*(N+1));
  localparam logic [2:0] D = 3'b001;
  localparam logic [2:0] U = 3'b010;
  localparam logic [2:0] L = 3'b100;

  typedef logic [31:0] w_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic step_ready = 1'b1;
  logic ram_en;
  logic [AL-1:0] ram_addr;
  logic [2:0] ram_data = 3'b000;
  logic step_valid;
  logic [2:0] step_dir;
  logic [BA-1:0] step_i;
  logic [BA-1:0] step_j;
  logic busy;
  logic done;
  logic error;

  logic [2:0] mem [25];
  w_t steps[$];
  w_t addrs[$];
  int done_cnt = 0;
  int total = 0;
  int bad = 0;

  traceback_direction_reader #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .ram_en(ram_en),
    .ram_addr(ram_addr),
    .ram_data(ram_data),
    .step_valid(step_valid),
    .step_ready(step_ready),
    .step_dir(step_dir),
    .step_i(step_i),
    .step_j(step_j),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) ram_data <= mem[ram_addr];
  end

  function automatic w_t stp(input logic [2:0] d, input int i, input int j);
    return {23'd0, d, 3'(i), 3'(j)};
  endfunction

  always @(posedge clk) begin
    if (step_valid && step_ready)
      steps.push_back(stp(step_dir, int'(step_i), int'(step_j)));
    if (ram_en) addrs.push_back(w_t'(ram_addr));
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input w_t obs, input w_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic init_mem();
    for (int r = 0; r <= N; r++)
      for (int c = 0; c <= N; c++)
        mem[r*(N+1)+c] = (r == 0) ? L : (c == 0) ? U : D;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", w_t'(done), 1);
  endtask

  task automatic check_walk(input string tag, input int s0, input int a0,
                            input int d0, input w_t es[$], input w_t ea[$]);
    repeat (2) @(negedge clk);
    chk({tag, "_nsteps"}, w_t'(steps.size() - s0), w_t'(es.size()));
    foreach (es[k])
      chk({tag, "_step"},
          (s0 + k < steps.size()) ? steps[s0+k] : 32'hffff_ffff, es[k]);
    chk({tag, "_naddr"}, w_t'(addrs.size() - a0), w_t'(ea.size()));
    foreach (ea[k])
      chk({tag, "_addr"},
          (a0 + k < addrs.size()) ? addrs[a0+k] : 32'hffff_ffff, ea[k]);
    chk({tag, "_done_cnt"}, w_t'(done_cnt - d0), 1);
    chk({tag, "_busy_end"}, w_t'(busy), 0);
  endtask

  initial begin
    w_t e1s[$];
    w_t e1a[$];
    w_t e2s[$];
    w_t e2a[$];
    int s0, a0, d0, cyc, n;

    e1s = '{stp(D,4,4), stp(D,3,3), stp(D,2,2), stp(D,1,1)};
    e1a = '{24, 18, 12, 6};
    e2s = '{stp(U,4,4), stp(U,3,4), stp(D,2,4),
            stp(D,1,3), stp(L,0,2), stp(L,0,1)};
    e2a = '{24, 19, 14, 8, 2, 1};
    init_mem();

    repeat (2) @(negedge clk);
    chk("reset_outputs",
        w_t'({ram_en, ram_addr, step_valid, step_dir, step_i, step_j,
              busy, done, error}), 0);
    rst = 1'b1;
    @(negedge clk);

    // all-diagonal walk
    s0 = steps.size(); a0 = addrs.size(); d0 = done_cnt;
    pulse_start();
    chk("t1_busy", w_t'(busy), 1);
    wait_done(cyc);
    chk("t1_cycles", w_t'(cyc), 12);
    check_walk("t1", s0, a0, d0, e1s, e1a);

    // up moves then row-0 left moves
    mem[24] = U;
    mem[19] = U;
    s0 = steps.size(); a0 = addrs.size(); d0 = done_cnt;
    pulse_start();
    wait_done(cyc);
    check_walk("t2", s0, a0, d0, e2s, e2a);
    init_mem();

    // back-pressure on the first step
    step_ready = 1'b0;
    s0 = steps.size(); a0 = addrs.size(); d0 = done_cnt;
    pulse_start();
    n = 0;
    while (!step_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t3_valid_first", w_t'(step_valid), 1);
    n = addrs.size();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("t3_valid_hold", w_t'(step_valid), 1);
      chk("t3_step_stable",
          stp(step_dir, int'(step_i), int'(step_j)), stp(D,4,4));
      chk("t3_no_ram_en", w_t'(ram_en), 0);
    end
    step_ready = 1'b1;
    @(negedge clk);
    chk("t3_valid_drop", w_t'(step_valid), 0);
    chk("t3_no_new_read", w_t'(addrs.size() - n), 0);
    wait_done(cyc);
    check_walk("t3", s0, a0, d0, e1s, e1a);

    // illegal symbol at (2,2)
    mem[12] = 3'b000;
    s0 = steps.size(); d0 = done_cnt;
    pulse_start();
    n = 0;
    while (!error && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t4_error", w_t'(error), 1);
    repeat (3) @(negedge clk);
    chk("t4_error_sticky", w_t'(error), 1);
    chk("t4_no_valid", w_t'(step_valid), 0);
    chk("t4_busy", w_t'(busy), 1);
    chk("t4_no_done", w_t'(done_cnt - d0), 0);
    chk("t4_nsteps", w_t'(steps.size() - s0), 2);
    chk("t4_step0", (s0 < steps.size()) ? steps[s0] : 32'hffff_ffff,
        stp(D,4,4));
    chk("t4_step1", (s0 + 1 < steps.size()) ? steps[s0+1] : 32'hffff_ffff,
        stp(D,3,3));
    mem[12] = D;
    s0 = steps.size(); a0 = addrs.size(); d0 = done_cnt;
    pulse_start();
    chk("t4_error_clear", w_t'(error), 0);
    wait_done(cyc);
    check_walk("t4r", s0, a0, d0, e1s, e1a);

    // reset during the second WAIT
    s0 = steps.size(); a0 = addrs.size();
    pulse_start();
    n = 0;
    while (addrs.size() - a0 < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b0;
    #1;
    chk("t5_reset_outputs",
        w_t'({ram_en, ram_addr, step_valid, step_dir, step_i, step_j,
              busy, done, error}), 0);
    repeat (2) @(negedge clk);
    chk("t5_nsteps", w_t'(steps.size() - s0), 1);
    rst = 1'b1;
    @(negedge clk);
    s0 = steps.size(); a0 = addrs.size(); d0 = done_cnt;
    pulse_start();
    wait_done(cyc);
    check_walk("t5", s0, a0, d0, e1s, e1a);

    // start while busy is ignored
    s0 = steps.size(); a0 = addrs.size(); d0 = done_cnt;
    pulse_start();
    repeat (4) @(negedge clk);
    pulse_start();
    wait_done(cyc);
    check_walk("t6", s0, a0, d0, e1s, e1a);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
